// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers, round-robin by default.
// Define UART_ARB_FIXED_PRIO_EN to select fixed priority (lowest set req index wins).
module uart_tx_arbiter #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned ACK_TIMEOUT = 16,
   localparam int unsigned GW = $clog2(N_REQ),
   localparam int unsigned CW = $clog2(ACK_TIMEOUT) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     ack,
   input  logic                 uart_ready,
   output logic                 uart_send,
   output logic [7:0]           uart_data,
   output logic                 busy,
   output logic [GW-1:0]        last_grant,
   output logic                 err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE} state_e;

   state_e           state_q;
   logic [N_REQ-1:0] ack_q, onehot_d;
   logic             send_q, err_q, found_d;
   logic [7:0]       data_q, byte_d;
   logic [GW-1:0]    win_q, win_d, last_q;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifndef UART_ARB_FIXED_PRIO_EN
   logic [GW-1:0]    idx_d;
`endif

   always_comb begin
      found_d  = 1'b0;
      win_d    = '0;
      onehot_d = '0;
      byte_d   = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!found_d && req[i]) begin
            found_d = 1'b1;
            win_d   = GW'(i);
         end
      end
`else
      idx_d = '0;
      // Start one past the last winner so the previous winner is searched last.
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx_d = GW'((32'(last_q) + k) % N_REQ);
         if (!found_d && req[idx_d]) begin
            found_d = 1'b1;
            win_d   = idx_d;
         end
      end
`endif
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win_d == GW'(i)) begin
            onehot_d[i] = 1'b1;
            byte_d      = req_data[8*i +: 8];
         end
      end
      cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         send_q  <= 1'b0;
         ack_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         last_q  <= GW'(N_REQ - 1);
         win_q   <= '0;
         cnt_q   <= '0;
      end else begin
         send_q <= 1'b0;
         ack_q  <= '0;
         case (state_q)
            IDLE: begin
               if (uart_ready && found_d) begin
                  win_q   <= win_d;
                  data_q  <= byte_d;
                  send_q  <= 1'b1;
                  ack_q   <= onehot_d;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               last_q  <= win_q;
               cnt_q   <= '0;
               state_q <= WAIT_ACCEPT;
            end
            WAIT_ACCEPT: begin
               if (!uart_ready) begin
                  state_q <= WAIT_DONE;
               end else begin
                  cnt_q <= cnt_d;
                  // Byte is dropped on timeout; its requester was already acked.
                  if (cnt_d == CW'(ACK_TIMEOUT - 1)) begin
                     err_q   <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
            WAIT_DONE: begin
               if (uart_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack        = ack_q;
   assign uart_send  = send_q;
   assign uart_data  = data_q;
   assign busy       = (state_q != IDLE);
   assign last_grant = last_q;
   assign err        = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter (ready/send/8-bit data handshake) between several byte producers in the glove design, e.g. the cursor-reset command, left/right and top/bottom gesture encoders, and a future debug streamer. Each requester presents one byte with a level request. The arbiter grants one requester at a time, round-robin by default. It issues a one-cycle `send` to the UART, returns a one-cycle acknowledge to the winner, and tracks the UART through busy/idle before the next grant.

## Interface
- `N_REQ`, default 4: number of requesters; legal values 2..8.
- `ACK_TIMEOUT`, default 16: cycles to wait for `uart_ready` to fall after `send` before declaring an error.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `req` in N_REQ: `req[i]`=1 means requester i has a byte pending; held until `ack[i]`.
- `req_data` in 8*N_REQ: byte of requester i on bits [8i+7:8i]; stable while `req[i]`=1.
- `ack` out N_REQ: one-hot, one-cycle pulse; the byte of requester i has been issued.
- `uart_ready` in 1: UART idle and able to accept `send`.
- `uart_send` out 1: one-cycle transmit strobe to the UART.
- `uart_data` out 8: byte to the UART; valid while `uart_send`=1 and held until the next grant.
- `busy` out 1: high in every state except IDLE.
- `last_grant` out clog2(N_REQ): index of the most recently granted requester.
- `err` out 1: sticky; set on acceptance timeout, cleared only by `rst`.

## Operation
- Reset values:
  - `uart_send`=0, `uart_data`=0, `ack`=0, `busy`=0, `err`=0.
  - `last_grant`=N_REQ-1, so requester 0 has first priority.
  - state=IDLE, timeout counter=0.
- IDLE: if `uart_ready`=1 and `|req`=1, select the winner and latch `req_data[winner]` into `uart_data`. Latch the winner index, then go to ISSUE. Otherwise stay.
- Round-robin selection: search from index `last_grant`+1 upward, wrapping from N_REQ-1 to 0. The first set `req` bit wins. `last_grant` itself is searched last.
- ISSUE, exactly one cycle:
  - `uart_send`=1 and `ack[winner]`=1 in the same cycle.
  - `last_grant` <= winner, timeout counter <= 0.
  - Go to WAIT_ACCEPT.
- WAIT_ACCEPT:
  - If `uart_ready`=0, go to WAIT_DONE.
  - Else increment the counter. When the counter reaches ACK_TIMEOUT-1 with `uart_ready` still 1, set `err` and go to IDLE. No retry; the byte is dropped and the requester has already been acked.
- WAIT_DONE: when `uart_ready`=1, go to IDLE.
- The byte is latched at grant, so if `req[winner]` drops during ISSUE the latched byte is still sent unchanged.
- Withdrawing a request without an ack is legal only while that requester is not the winner. The arbiter re-evaluates `req` every IDLE cycle.
- Simultaneous requests: exactly one wins per grant. The losers keep requesting and are served in rotation order.
- A requester may re-assert `req` the cycle after its `ack`. Under round-robin it is then behind every other pending requester.
- Illegal state encodings return to IDLE.

## Timing
- From `req` rising in IDLE with `uart_ready`=1:
  - `uart_send` and `ack` assert 1 cycle later, at the ISSUE cycle.
- Back-to-back bytes: the next grant happens in the first IDLE cycle after `uart_ready` returns high. With a UART that drops `ready` the cycle after `send`, the minimum per-byte overhead beyond UART frame time is 3 cycles.
- Reset mid-operation: all outputs return to reset values immediately and asynchronously. A byte already in the UART completes or aborts under the UART's own reset.

## Configuration
- `UART_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority; the lowest set `req` index always wins. `last_grant` is still updated but ignored for selection.
  - Undefined (default): round-robin as described above.

## Test plan
- Single requester: `req`=4'b0100, byte 8'h63, UART model drops ready 1 cycle after send and holds it low 10 cycles. Required:
  - `uart_send` pulse with `uart_data`=8'h63 and `ack`=4'b0100 in the same cycle, one cycle after `req`.
  - `last_grant`=2.
- Contention, round-robin: `req`=4'b1111 held, re-raised after each ack. Required:
  - Grant order 0,1,2,3,0.
  - Exactly one `ack` bit per `uart_send`.
- Fixed priority (`UART_ARB_FIXED_PRIO_EN` defined): `req[0]` and `req[3]` continuously asserted. Required: requester 0 wins every grant and `ack[3]` never pulses.
- Acceptance timeout: UART model keeps `uart_ready`=1 after send. Required:
  - `err` rises 16 cycles after ISSUE and stays set.
  - The arbiter returns to IDLE, and the next request is granted normally.
- UART busy: `req`=4'b0001 while `uart_ready`=0 for 20 cycles. Required: no `uart_send` until ready rises, then send on the cycle after ready is sampled high.
- Reset mid-transfer: assert `rst` during WAIT_DONE. Required:
  - All outputs return to reset values without waiting for a clock edge.
  - After release, with `req`=4'b1001, requester 0 is granted first.
